// File: rtl/swap_reg_bank.sv
// Bank of DEPTH general-purpose registers with LOAD/INC/CLR and a two-phase SWAP.
// Optional macro SWPBANK_INC_SAT_EN makes INC saturate at all-ones instead of wrapping.
module swap_reg_bank #(
  parameter int WIDTH   = 18,
  parameter int DEPTH   = 4,
  parameter int ADDR_W  = 2,
  parameter int RST_VAL = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [1:0]        op,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [WIDTH-1:0]  bus_in,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data,
  output logic              swp_done,
  output logic              ovf
);

  typedef enum logic {IDLE, SWP2} state_t;
  typedef logic [DEPTH-1:0][WIDTH-1:0] bank_t;

  localparam logic [WIDTH-1:0] RST_W = WIDTH'(RST_VAL);
  localparam logic [WIDTH-1:0] ONES  = '1;
  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_INC  = 2'b01;
  localparam logic [1:0] OP_SWAP = 2'b10;
  localparam logic [1:0] OP_CLR  = 2'b11;

  state_t            state_q, state_d;
  bank_t             regs_q, regs_d;
  logic [WIDTH-1:0]  tmp_q, tmp_d;
  logic [ADDR_W-1:0] b_q, b_d;
  logic              swp_ok_q, swp_ok_d;
  logic              swp_done_q, swp_done_d;
  logic              ovf_q, ovf_d;

  logic              a_in, b_in, accept;
  logic [WIDTH-1:0]  val_a, val_b, inc_val;

  // Out-of-range addresses read as 0 and never match a write slot.
  function automatic logic [WIDTH-1:0] rd_reg(input bank_t r, input logic [ADDR_W-1:0] ad);
    rd_reg = '0;
    for (int i = 0; i < DEPTH; i++)
      if (ad == ADDR_W'(i)) rd_reg = r[i];
  endfunction

  function automatic bank_t wr_reg(input bank_t r, input logic [ADDR_W-1:0] ad,
                                   input logic [WIDTH-1:0] v);
    wr_reg = r;
    for (int i = 0; i < DEPTH; i++)
      if (ad == ADDR_W'(i)) wr_reg[i] = v;
  endfunction

  function automatic logic in_range(input logic [ADDR_W-1:0] ad);
    in_range = ({1'b0, ad} < (ADDR_W+1)'(DEPTH));
  endfunction

  assign a_in     = in_range(addr_a);
  assign b_in     = in_range(addr_b);
  assign val_a    = rd_reg(regs_q, addr_a);
  assign val_b    = rd_reg(regs_q, addr_b);
  assign op_ready = en & (state_q == IDLE);
  assign accept   = op_ready & op_valid;

`ifdef SWPBANK_INC_SAT_EN
  assign inc_val = (val_a == ONES) ? ONES : val_a + WIDTH'(1);
`else
  assign inc_val = val_a + WIDTH'(1);
`endif

  always_comb begin
    regs_d     = regs_q;
    tmp_d      = tmp_q;
    b_d        = b_q;
    swp_ok_d   = swp_ok_q;
    state_d    = state_q;
    swp_done_d = 1'b0;
    ovf_d      = 1'b0;
    if (en && state_q == SWP2) begin
      if (swp_ok_q) regs_d = wr_reg(regs_q, b_q, tmp_q);
      swp_done_d = 1'b1;
      state_d    = IDLE;
    end else if (accept) begin
      case (op)
        OP_LOAD: if (a_in) regs_d = wr_reg(regs_q, addr_a, bus_in);
        OP_INC: if (a_in) begin
          regs_d = wr_reg(regs_q, addr_a, inc_val);
          ovf_d  = (val_a == ONES);
        end
        OP_SWAP: begin
          // A swap touching any out-of-range register still runs both phases but writes nothing.
          tmp_d    = val_a;
          swp_ok_d = a_in & b_in;
          b_d      = addr_b;
          state_d  = SWP2;
          if (a_in && b_in) regs_d = wr_reg(regs_q, addr_a, val_b);
        end
        OP_CLR: if (a_in) regs_d = wr_reg(regs_q, addr_a, '0);
        default: ;
      endcase
    end
  end

  always_ff @(negedge clk) begin
    if (rst) begin
      regs_q     <= {DEPTH{RST_W}};
      tmp_q      <= '0;
      b_q        <= '0;
      swp_ok_q   <= 1'b0;
      state_q    <= IDLE;
      swp_done_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      regs_q     <= regs_d;
      tmp_q      <= tmp_d;
      b_q        <= b_d;
      swp_ok_q   <= swp_ok_d;
      state_q    <= state_d;
      swp_done_q <= swp_done_d;
      ovf_q      <= ovf_d;
    end
  end

  assign rd_data  = rd_reg(regs_q, rd_addr);
  assign swp_done = swp_done_q;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_swap_reg_bank.sv
// Bench for swap_reg_bank: directed vector table, hand sequences, randomized ops vs a register-array model.
module tb_swap_reg_bank;
  localparam int W = 18, D = 4, AW = 2;
  localparam logic [W-1:0] MAX = '1;
`ifdef SWPBANK_INC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, en, op_valid;
  logic [1:0] op;
  logic [AW-1:0] addr_a, addr_b, rd_addr;
  logic [W-1:0] bus_in, rd_data, rd_data3;
  logic op_ready, swp_done, ovf, op_ready3, swp_done3, ovf3;

  swap_reg_bank #(.WIDTH(W), .DEPTH(D), .ADDR_W(AW), .RST_VAL(2)) u_dut (
    .clk(clk), .rst(rst), .en(en), .op_valid(op_valid), .op_ready(op_ready), .op(op),
    .addr_a(addr_a), .addr_b(addr_b), .bus_in(bus_in), .rd_addr(rd_addr),
    .rd_data(rd_data), .swp_done(swp_done), .ovf(ovf));

  swap_reg_bank #(.WIDTH(W), .DEPTH(3), .ADDR_W(AW), .RST_VAL(2)) u_dut3 (
    .clk(clk), .rst(rst), .en(en), .op_valid(op_valid), .op_ready(op_ready3), .op(op),
    .addr_a(addr_a), .addr_b(addr_b), .bus_in(bus_in), .rd_addr(rd_addr),
    .rd_data(rd_data3), .swp_done(swp_done3), .ovf(ovf3));

  always #10 clk = ~clk;

  int n_chk = 0, n_err = 0;

  // reference: plain register array plus the pending second half of a swap
  logic [W-1:0]  m [D];
  bit            pend, pok;
  logic [AW-1:0] pb;
  logic [W-1:0]  ptmp;
  bit            e_done, e_ovf;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    e_done = 0; e_ovf = 0;
    if (rst) begin
      for (int i = 0; i < D; i++) m[i] = W'(2);
      pend = 0;
    end else if (en) begin
      if (pend) begin
        if (pok) m[pb] = ptmp;
        e_done = 1; pend = 0;
      end else if (op_valid) begin
        case (op)
          2'd0: if (int'(addr_a) < D) m[addr_a] = bus_in;
          2'd1: if (int'(addr_a) < D) begin
            if (m[addr_a] == MAX) begin e_ovf = 1; m[addr_a] = SAT ? MAX : '0; end
            else m[addr_a] = m[addr_a] + 1;
          end
          2'd2: begin
            pok  = (int'(addr_a) < D) && (int'(addr_b) < D);
            ptmp = pok ? m[addr_a] : '0;
            if (pok) m[addr_a] = m[addr_b];
            pb = addr_b; pend = 1;
          end
          default: if (int'(addr_a) < D) m[addr_a] = '0;
        endcase
      end
    end
  endtask

  task automatic cyc(input logic r, input logic e, input logic v, input logic [1:0] o,
                     input logic [AW-1:0] a, input logic [AW-1:0] b, input logic [W-1:0] d);
    rst = r; en = e; op_valid = v; op = o; addr_a = a; addr_b = b; bus_in = d;
    model_edge();
    @(negedge clk); #1;
  endtask

  task automatic chk_all(input string tag);
    chk({tag, "_rdy"}, 32'(op_ready), 32'(en && !pend));
    chk({tag, "_done"}, 32'(swp_done), 32'(e_done));
    chk({tag, "_ovf"}, 32'(ovf), 32'(e_ovf));
    for (int i = 0; i < D; i++) begin
      rd_addr = AW'(i); #1;
      chk($sformatf("%s_r%0d", tag, i), 32'(rd_data), 32'(m[i]));
    end
  endtask

  task automatic rd_chk(input string nm, input logic [AW-1:0] a, input logic [W-1:0] exp);
    rd_addr = a; #1;
    chk(nm, 32'(rd_data), 32'(exp));
  endtask

  typedef struct {
    logic r, e, v;
    logic [1:0] o;
    logic [AW-1:0] a, b;
    logic [W-1:0] d;
    logic [AW-1:0] ra;
    logic [W-1:0] er;
    logic ery, edn, eov;
  } vec_t;

  vec_t tv [13];

  function automatic vec_t mk(logic r, logic v, logic [1:0] o, logic [AW-1:0] a, logic [AW-1:0] b,
                              logic [W-1:0] d, logic [AW-1:0] ra, logic [W-1:0] er,
                              logic ery, logic edn, logic eov);
    vec_t t;
    t.r = r; t.e = 1'b1; t.v = v; t.o = o; t.a = a; t.b = b; t.d = d;
    t.ra = ra; t.er = er; t.ery = ery; t.edn = edn; t.eov = eov;
    return t;
  endfunction

  initial begin
    rd_addr = '0;
    //            rst vld op  a  b  data       rd exp_rd               rdy done ovf
    tv[0]  = mk(1, 0, 2'd0, 0, 0, 18'h0,     0, 18'd2,                 1, 0, 0);
    tv[1]  = mk(0, 1, 2'd0, 1, 0, 18'h1ABCD, 1, 18'h1ABCD,             1, 0, 0);
    tv[2]  = mk(0, 0, 2'd0, 0, 0, 18'h0,     2, 18'd2,                 1, 0, 0);
    tv[3]  = mk(0, 1, 2'd0, 0, 0, 18'd5,     0, 18'd5,                 1, 0, 0);
    tv[4]  = mk(0, 1, 2'd0, 3, 0, 18'd9,     3, 18'd9,                 1, 0, 0);
    tv[5]  = mk(0, 1, 2'd2, 0, 3, 18'h0,     0, 18'd9,                 0, 0, 0);
    tv[6]  = mk(0, 1, 2'd0, 3, 0, 18'h777,   3, 18'd5,                 1, 1, 0);
    tv[7]  = mk(0, 0, 2'd0, 0, 0, 18'h0,     0, 18'd9,                 1, 0, 0);
    tv[8]  = mk(0, 1, 2'd0, 2, 0, 18'h3FFFF, 2, 18'h3FFFF,             1, 0, 0);
    tv[9]  = mk(0, 1, 2'd1, 2, 0, 18'h0,     2, SAT ? 18'h3FFFF : 18'h0, 1, 0, 1);
    tv[10] = mk(0, 0, 2'd0, 0, 0, 18'h0,     2, SAT ? 18'h3FFFF : 18'h0, 1, 0, 0);
    tv[11] = mk(0, 1, 2'd2, 1, 1, 18'h0,     1, 18'h1ABCD,             0, 0, 0);
    tv[12] = mk(0, 0, 2'd0, 0, 0, 18'h0,     1, 18'h1ABCD,             1, 1, 0);

    for (int i = 0; i < 13; i++) begin
      cyc(tv[i].r, tv[i].e, tv[i].v, tv[i].o, tv[i].a, tv[i].b, tv[i].d);
      rd_chk($sformatf("tv%0d_rd", i), tv[i].ra, tv[i].er);
      chk($sformatf("tv%0d_rdy", i), 32'(op_ready), 32'(tv[i].ery));
      chk($sformatf("tv%0d_done", i), 32'(swp_done), 32'(tv[i].edn));
      chk($sformatf("tv%0d_ovf", i), 32'(ovf), 32'(tv[i].eov));
      chk_all($sformatf("tv%0d", i));
    end

    // swap stalled by en low between its phases
    cyc(0, 1, 1, 2'd0, 0, 0, 18'd5); chk_all("st_ld0");
    cyc(0, 1, 1, 2'd0, 3, 0, 18'd9); chk_all("st_ld3");
    cyc(0, 1, 1, 2'd2, 0, 3, 18'd0);
    rd_chk("st_p1_r0", 0, 18'd9);
    rd_chk("st_p1_r3", 3, 18'd9);
    for (int k = 0; k < 3; k++) begin
      cyc(0, 0, 1, 2'd0, 3, 0, 18'h123);
      rd_chk($sformatf("st_hold%0d_r3", k), 3, 18'd9);
      chk($sformatf("st_hold%0d_done", k), 32'(swp_done), 32'd0);
      chk($sformatf("st_hold%0d_rdy", k), 32'(op_ready), 32'd0);
    end
    cyc(0, 1, 0, 2'd0, 0, 0, 18'd0);
    rd_chk("st_end_r3", 3, 18'd5);
    rd_chk("st_end_r0", 0, 18'd9);
    chk("st_end_done", 32'(swp_done), 32'd1);
    chk_all("st_end");

    // reset in the middle of a swap
    cyc(0, 1, 1, 2'd2, 1, 2, 18'd0); chk_all("mr_p1");
    cyc(1, 1, 1, 2'd0, 0, 0, 18'd0);
    rd_chk("mr_r1", 1, 18'd2);
    rd_chk("mr_r2", 2, 18'd2);
    chk("mr_done", 32'(swp_done), 32'd0);
    chk("mr_rdy", 32'(op_ready), 32'd1);
    chk_all("mr");
    cyc(0, 1, 0, 2'd0, 0, 0, 18'd0);
    chk("mr_nodone", 32'(swp_done), 32'd0);
    chk_all("mr_after");

    // reset wins over en low
    cyc(0, 1, 1, 2'd0, 0, 0, 18'd7); chk_all("re_ld");
    cyc(1, 0, 0, 2'd0, 0, 0, 18'd0);
    rd_chk("re_r0", 0, 18'd2);
    chk_all("re");

    // out-of-range write on the DEPTH=3 instance
    cyc(0, 1, 1, 2'd0, 3, 0, 18'h155);
    rd_addr = 2'd3; #1;
    chk("d3_rd3", 32'(rd_data3), 32'd0);
    chk("d4_rd3", 32'(rd_data), 32'h155);
    for (int i = 0; i < 3; i++) begin
      rd_addr = AW'(i); #1;
      chk($sformatf("d3_r%0d", i), 32'(rd_data3), 32'd2);
    end
    chk_all("d3");

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      cyc($urandom_range(0, 49) == 0, $urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0,
          2'($urandom), AW'($urandom), AW'($urandom),
          ($urandom_range(0, 3) == 0) ? MAX : W'($urandom));
      chk_all($sformatf("rnd%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/swap_reg_bank.md
# swap_reg_bank

- Parametrised bank of DEPTH general-purpose registers for the down-sampling processor datapath.
- Each register resets to a fixed pointer/constant value, like the existing single swap registers.
- Operations are issued over a valid/ready port: load from the data bus, increment, clear, and a two-phase swap between any two registers.
- Sits between the processor bus and the ALU operand path, replacing individually instantiated swap registers.

## Interface
Parameters:
- WIDTH, 18, register and bus width in bits
- DEPTH, 4, number of registers (2..16)
- ADDR_W, 2, address width; must satisfy 2^ADDR_W >= DEPTH
- RST_VAL, 2, reset value of every register (truncated to WIDTH)

Ports:
- clk  in  1  clock; all state updates on the falling edge
- rst  in  1  reset, synchronous, active-high
- en  in  1  global update enable; low freezes all state including the swap FSM
- op_valid  in  1  operation request
- op_ready  out  1  bank can accept an operation
- op  in  2  00 LOAD, 01 INC, 10 SWAP, 11 CLR
- addr_a  in  ADDR_W  target register (all ops)
- addr_b  in  ADDR_W  second register (SWAP only)
- bus_in  in  WIDTH  load data
- rd_addr  in  ADDR_W  read port address
- rd_data  out  WIDTH  combinational read of reg[rd_addr]
- swp_done  out  1  one-cycle pulse on SWAP completion
- ovf  out  1  one-cycle pulse when INC wraps or saturates

## Operation
- **Accept condition:** an op is accepted on a falling edge when op_valid & op_ready & en are all high.
- **LOAD:** reg[addr_a] <= bus_in.
- **INC:** reg[addr_a] <= reg[addr_a] + 1, modulo 2^WIDTH. ovf pulses if the old value was all-ones (see Configuration).
- **CLR:** reg[addr_a] <= 0.
- **SWAP (FSM IDLE -> SWP2 -> IDLE):**
  - On acceptance: tmp <= reg[addr_a]; reg[addr_a] <= reg[addr_b]; latch addr_b internally; go to SWP2.
  - In SWP2: reg[latched b] <= tmp; swp_done <= 1; return to IDLE.
- **Ready:** op_ready = en & (state == IDLE).
- **Out-of-range addresses:** addr_a, addr_b or rd_addr >= DEPTH. Writes are ignored. rd_data returns 0. A SWAP with an out-of-range operand still runs both phases and pulses swp_done, but modifies nothing.
- **SWAP with addr_a == addr_b:** runs both phases, pulses swp_done, register value unchanged.
- **en low:** no op is accepted and an SWP2 phase stalls. The FSM holds state and tmp, and swp_done/ovf stay 0. The swap resumes on the first edge with en high.
- **Inputs during SWP2:** op_valid and the op inputs are ignored.
- **Reset:** on any edge with rst high, including mid-SWAP:
  - all registers <= RST_VAL, tmp <= 0, state <= IDLE
  - swp_done <= 0, ovf <= 0
  - rst overrides en.

## Timing
- All registers update on the negedge of clk. rd_data is combinational from register state.
- LOAD/INC/CLR: new value visible on rd_data immediately after the accepting edge (latency 1 edge).
- SWAP:
  - reg[a] updated after edge 1; reg[b] updated after edge 2 (with en continuously high).
  - swp_done high for exactly the cycle after edge 2.
  - op_ready low for the cycle between edge 1 and edge 2.
- ovf is high for exactly one cycle after the INC edge.
- Back-to-back ops: a new op may be accepted on the edge immediately after a LOAD/INC/CLR edge, and on the edge after a SWP2 edge.
- Reset values: registers = RST_VAL, rd_data = RST_VAL for valid rd_addr, op_ready = en, swp_done = 0, ovf = 0.

## Configuration
- Macro: SWPBANK_INC_SAT_EN.
- Defined: INC on an all-ones register leaves it at all-ones and pulses ovf.
- Undefined (default): INC wraps all-ones to 0 and pulses ovf.
- All other behaviour is identical in both builds.

## Test plan
- Reset: rst high for 1 edge with defaults -> reading regs 0..3 gives 2 each; op_ready=1, swp_done=0, ovf=0.
- LOAD then read: LOAD a=1, bus_in=18'h1ABCD -> rd_data(1)=18'h1ABCD after the edge; other regs still 2.
- SWAP sequence: reg0=5, reg3=9, SWAP a=0 b=3 -> after edge 1 reg0=9, reg3=9, op_ready=0; after edge 2 reg0=9, reg3=5, swp_done pulses once.
- INC boundary: LOAD a=2 with 18'h3FFFF, then INC a=2 -> reg2=0 with ovf pulse (macro undefined); reg2=18'h3FFFF with ovf pulse (SWPBANK_INC_SAT_EN defined).
- Stall and mid-op reset:
  - en dropped for 3 edges between SWAP phases -> reg[b] unchanged and swp_done=0 until en returns; swap then completes.
  - Separate run: rst asserted in SWP2 -> all regs=2, state IDLE, no swp_done.
- Edge cases:
  - SWAP a=b=1 -> swp_done pulses, reg1 unchanged.
  - LOAD a=3 with DEPTH=3 -> no register changes; rd_addr=3 gives rd_data=0.
